// File: rtl/rasterizer_pkg.sv
// Shared types for the rasterizer backend: FSM states, coordinate/edge widths and vector types.
package rasterizer_pkg;

    localparam int DW = 12;
    localparam int EW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } backend_state_t;

    typedef logic signed [DW-1:0] coord_t;
    typedef logic signed [EW-1:0] edge_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vec2_t;

endpackage

// File: rtl/rasterizer_backend_edge_stepper.sv
// Row/current accumulator pair for one incrementally stepped plane equation (edge or z).
module edge_stepper #(
    parameter int ACC_W   = 24,
    parameter int DELTA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     step_x_i,
    input  logic                     step_row_i,
    input  logic signed [ACC_W-1:0]  init_i,
    input  logic signed [DELTA_W-1:0] dx_i,
    input  logic signed [DELTA_W-1:0] dy_i,
    output logic signed [ACC_W-1:0]  cur_o
);

    logic signed [ACC_W-1:0] row_q;
    logic signed [ACC_W-1:0] cur_q;
    logic signed [ACC_W-1:0] dx_q;
    logic signed [ACC_W-1:0] dy_q;
    logic signed [ACC_W-1:0] row_d;

    assign row_d = row_q + dy_q;
    assign cur_o = cur_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            cur_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
        end else if (load_i) begin
            row_q <= init_i;
            cur_q <= init_i;
            dx_q  <= {{(ACC_W-DELTA_W){dx_i[DELTA_W-1]}}, dx_i};
            dy_q  <= {{(ACC_W-DELTA_W){dy_i[DELTA_W-1]}}, dy_i};
        end else if (step_row_i) begin
            // New row restarts from the left column of the row below.
            row_q <= row_d;
            cur_q <= row_d;
        end else if (step_x_i) begin
            cur_q <= cur_q + dx_q;
        end
    end

endmodule

// File: rtl/rasterizer_backend.sv
// Walks a set-up triangle's bounding box one pixel per clock and streams covered fragments.
module rasterizer_backend
    import rasterizer_pkg::*;
#(
    parameter int DATAWIDTH = DW
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          ready,
    input  logic                          i_dv,
    input  logic signed [DATAWIDTH-1:0]   i_bb_tl [2],
    input  logic signed [DATAWIDTH-1:0]   i_bb_br [2],
    input  logic signed [2*DATAWIDTH-1:0] i_edge_val0,
    input  logic signed [2*DATAWIDTH-1:0] i_edge_val1,
    input  logic signed [2*DATAWIDTH-1:0] i_edge_val2,
    input  logic signed [DATAWIDTH-1:0]   i_edge_delta0 [2],
    input  logic signed [DATAWIDTH-1:0]   i_edge_delta1 [2],
    input  logic signed [DATAWIDTH-1:0]   i_edge_delta2 [2],
    input  logic [DATAWIDTH-1:0]          i_z_coeff,
    input  logic signed [DATAWIDTH-1:0]   i_z_coeff_delta [2],
    output logic signed [DATAWIDTH-1:0]   o_x,
    output logic signed [DATAWIDTH-1:0]   o_y,
    output logic [DATAWIDTH-1:0]          o_z,
    output logic                          o_dv,
    input  logic                          i_ready,
    output logic                          o_done,
    output backend_state_t                o_state
);

    localparam int AW = 2 * DATAWIDTH;
    localparam int ZW = DATAWIDTH + 2;
    localparam logic signed [AW-1:0] E_ZERO = '0;
    localparam logic signed [ZW-1:0] Z_ZERO = '0;
    localparam logic signed [ZW-1:0] Z_MAX  = ZW'((1 << DATAWIDTH) - 1);

    backend_state_t state_q;
    logic signed [DATAWIDTH-1:0] tl_x_q, tl_y_q, br_x_q, br_y_q;
    logic signed [DATAWIDTH-1:0] x_q, y_q, x_d, y_d;

    // Evaluation stage: result of the pixel stepped on the previous unstalled clock.
    logic                        ev_vld_q, ev_cov_q;
    logic signed [DATAWIDTH-1:0] ev_x_q, ev_y_q;
    logic [DATAWIDTH-1:0]        ev_z_q;

    logic                        o_dv_q, o_done_q;
    logic signed [DATAWIDTH-1:0] o_x_q, o_y_q;
    logic [DATAWIDTH-1:0]        o_z_q;

    logic signed [AW-1:0]        edge_init [3];
    logic signed [DATAWIDTH-1:0] edge_dx [3];
    logic signed [DATAWIDTH-1:0] edge_dy [3];
    logic signed [AW-1:0]        edge_cur [3];
    logic signed [ZW-1:0]        z_cur;
    logic [DATAWIDTH-1:0]        z_clamped;

    logic load, out_free, degen, last_px, row_end, scan_go, step_x, step_row, covered;

    assign edge_init[0] = i_edge_val0;
    assign edge_init[1] = i_edge_val1;
    assign edge_init[2] = i_edge_val2;
    assign edge_dx[0]   = i_edge_delta0[0];
    assign edge_dy[0]   = i_edge_delta0[1];
    assign edge_dx[1]   = i_edge_delta1[0];
    assign edge_dy[1]   = i_edge_delta1[1];
    assign edge_dx[2]   = i_edge_delta2[0];
    assign edge_dy[2]   = i_edge_delta2[1];

    assign ready    = (state_q == S_IDLE);
    assign load     = ready && i_dv;
    assign out_free = !(o_dv_q && !i_ready);
    assign degen    = (tl_x_q > br_x_q) || (tl_y_q > br_y_q);
    assign row_end  = (x_q == br_x_q);
    assign last_px  = row_end && (y_q == br_y_q);
    assign scan_go  = (state_q == S_SCAN) && !degen && out_free;
    assign step_x   = scan_go && !last_px && !row_end;
    assign step_row = scan_go && !last_px && row_end;
    assign covered  = (edge_cur[0] >= E_ZERO) && (edge_cur[1] >= E_ZERO) && (edge_cur[2] >= E_ZERO);

    for (genvar g = 0; g < 3; g++) begin : g_edge
        edge_stepper #(.ACC_W(AW), .DELTA_W(DATAWIDTH)) u_edge (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load),
            .step_x_i  (step_x),
            .step_row_i(step_row),
            .init_i    (edge_init[g]),
            .dx_i      (edge_dx[g]),
            .dy_i      (edge_dy[g]),
            .cur_o     (edge_cur[g])
        );
    end

    edge_stepper #(.ACC_W(ZW), .DELTA_W(DATAWIDTH)) u_z (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_x_i  (step_x),
        .step_row_i(step_row),
        .init_i    ({2'b00, i_z_coeff}),
        .dx_i      (i_z_coeff_delta[0]),
        .dy_i      (i_z_coeff_delta[1]),
        .cur_o     (z_cur)
    );

    always_comb begin
        z_clamped = z_cur[DATAWIDTH-1:0];
        if (z_cur < Z_ZERO) begin
            z_clamped = '0;
        end else if (z_cur > Z_MAX) begin
            z_clamped = '1;
        end
    end

    always_comb begin
        x_d = x_q + DATAWIDTH'(1);
        y_d = y_q;
        if (row_end) begin
            x_d = tl_x_q;
            y_d = y_q + DATAWIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tl_x_q   <= '0;
            tl_y_q   <= '0;
            br_x_q   <= '0;
            br_y_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ev_vld_q <= 1'b0;
            ev_cov_q <= 1'b0;
            ev_x_q   <= '0;
            ev_y_q   <= '0;
            ev_z_q   <= '0;
            o_dv_q   <= 1'b0;
            o_done_q <= 1'b0;
            o_x_q    <= '0;
            o_y_q    <= '0;
            o_z_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    o_done_q <= 1'b0;
                    if (i_dv) begin
                        tl_x_q  <= i_bb_tl[0];
                        tl_y_q  <= i_bb_tl[1];
                        br_x_q  <= i_bb_br[0];
                        br_y_q  <= i_bb_br[1];
                        x_q     <= i_bb_tl[0];
                        y_q     <= i_bb_tl[1];
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (degen) begin
                        state_q  <= S_DONE;
                        o_done_q <= 1'b1;
                    end else if (out_free) begin
                        ev_vld_q <= 1'b1;
                        ev_cov_q <= covered;
                        ev_x_q   <= x_q;
                        ev_y_q   <= y_q;
                        ev_z_q   <= z_clamped;
                        x_q      <= x_d;
                        y_q      <= y_d;
                        if (last_px) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Finish only once the evaluation stage is empty and the output slot is free.
                    if (out_free) begin
                        ev_vld_q <= 1'b0;
                        if (!ev_vld_q) begin
                            state_q  <= S_DONE;
                            o_done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    o_done_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (out_free) begin
                o_dv_q <= ev_vld_q && ev_cov_q;
                if (ev_vld_q && ev_cov_q) begin
                    o_x_q <= ev_x_q;
                    o_y_q <= ev_y_q;
                    o_z_q <= ev_z_q;
                end
            end
        end
    end

    assign o_x     = o_x_q;
    assign o_y     = o_y_q;
    assign o_z     = o_z_q;
    assign o_dv    = o_dv_q;
    assign o_done  = o_done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_rasterizer_backend.sv
// Directed, table-driven bench for rasterizer_backend with a fragment scoreboard.
module tb_rasterizer_backend;
    import rasterizer_pkg::*;

    typedef struct {
        coord_t          tl_x, tl_y, br_x, br_y;
        edge_t           e0, e1, e2;
        coord_t          d0x, d0y, d1x, d1y, d2x, d2y;
        logic [DW-1:0]   z;
        coord_t          dzx, dzy;
        int              done_cyc;
        int              n;
        coord_t          ex [16];
        coord_t          ey [16];
        logic [DW-1:0]   ez [16];
    } vec_t;

    localparam int NVEC = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           ready, i_dv, i_ready, o_dv, o_done;
    coord_t         bb_tl [2], bb_br [2];
    edge_t          e_val0, e_val1, e_val2;
    coord_t         d0 [2], d1 [2], d2 [2], dz [2];
    logic [DW-1:0]  z_coeff;
    coord_t         o_x, o_y;
    logic [DW-1:0]  o_z;
    backend_state_t dbg_state;

    rasterizer_backend #(.DATAWIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .i_dv           (i_dv),
        .i_bb_tl        (bb_tl),
        .i_bb_br        (bb_br),
        .i_edge_val0    (e_val0),
        .i_edge_val1    (e_val1),
        .i_edge_val2    (e_val2),
        .i_edge_delta0  (d0),
        .i_edge_delta1  (d1),
        .i_edge_delta2  (d2),
        .i_z_coeff      (z_coeff),
        .i_z_coeff_delta(dz),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_z            (o_z),
        .o_dv           (o_dv),
        .i_ready        (i_ready),
        .o_done         (o_done),
        .o_state        (dbg_state)
    );

    vec_t vec [NVEC];
    logic [3*DW-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_tri(input int i, input int tlx, input int tly, input int brx, input int bry,
                           input int e0, input int e1, input int e2,
                           input int d0x, input int d0y, input int d1x, input int d1y,
                           input int d2x, input int d2y,
                           input int z, input int dzx, input int dzy, input int done_cyc);
        vec[i].tl_x = DW'(tlx);  vec[i].tl_y = DW'(tly);
        vec[i].br_x = DW'(brx);  vec[i].br_y = DW'(bry);
        vec[i].e0 = EW'(e0);     vec[i].e1 = EW'(e1);     vec[i].e2 = EW'(e2);
        vec[i].d0x = DW'(d0x);   vec[i].d0y = DW'(d0y);
        vec[i].d1x = DW'(d1x);   vec[i].d1y = DW'(d1y);
        vec[i].d2x = DW'(d2x);   vec[i].d2y = DW'(d2y);
        vec[i].z = DW'(z);       vec[i].dzx = DW'(dzx);   vec[i].dzy = DW'(dzy);
        vec[i].done_cyc = done_cyc;
        vec[i].n = 0;
    endtask

    task automatic add_frag(input int i, input int x, input int y, input int z);
        vec[i].ex[vec[i].n] = DW'(x);
        vec[i].ey[vec[i].n] = DW'(y);
        vec[i].ez[vec[i].n] = DW'(z);
        vec[i].n++;
    endtask

    // driver
    task automatic apply_vec(input int i);
        bb_tl[0] = vec[i].tl_x;  bb_tl[1] = vec[i].tl_y;
        bb_br[0] = vec[i].br_x;  bb_br[1] = vec[i].br_y;
        e_val0 = vec[i].e0;      e_val1 = vec[i].e1;      e_val2 = vec[i].e2;
        d0[0] = vec[i].d0x;      d0[1] = vec[i].d0y;
        d1[0] = vec[i].d1x;      d1[1] = vec[i].d1y;
        d2[0] = vec[i].d2x;      d2[1] = vec[i].d2y;
        z_coeff = vec[i].z;      dz[0] = vec[i].dzx;      dz[1] = vec[i].dzy;
    endtask

    // Accept one triangle and score every fragment; stall holds i_ready low after the first one.
    task automatic run_case(input int i, input int stall);
        int cyc, got, first, stall_left;
        bit done_seen;
        exp_q.delete();
        for (int k = 0; k < vec[i].n; k++) begin
            exp_q.push_back({vec[i].ex[k], vec[i].ey[k], vec[i].ez[k]});
        end
        apply_vec(i);
        i_ready = 1'b1;
        check($sformatf("ready_idle[%0d]", i), ready, 1);
        i_dv = 1'b1;
        @(posedge clk);
        #1 i_dv = 1'b0;
        cyc = 0; got = 0; first = -1; done_seen = 1'b0; stall_left = stall;
        while (!done_seen && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check($sformatf("ready_busy[%0d]", i), ready, 0);
            if (o_dv && first < 0) first = cyc;
            if (first >= 0 && stall_left > 0) begin
                i_ready = 1'b0;
                stall_left--;
                check($sformatf("stall_dv[%0d]", i), o_dv, 1);
                if (exp_q.size() > 0)
                    check($sformatf("stall_hold[%0d]", i), {o_x, o_y, o_z}, exp_q[0]);
            end else begin
                i_ready = 1'b1;
            end
            if (o_dv && i_ready) begin
                if (exp_q.size() > 0) begin
                    check($sformatf("frag[%0d.%0d]", i, got), {o_x, o_y, o_z}, exp_q.pop_front());
                end else begin
                    check($sformatf("extra_frag[%0d]", i), got, vec[i].n);
                end
                got++;
            end
            if (o_done) begin
                done_seen = 1'b1;
                check($sformatf("done_cyc[%0d]", i), cyc, vec[i].done_cyc + stall);
            end
        end
        i_ready = 1'b1;
        check($sformatf("done_seen[%0d]", i), done_seen, 1);
        check($sformatf("frag_count[%0d]", i), got, vec[i].n);
        if (vec[i].n > 0) check($sformatf("first_latency[%0d]", i), first, 2);
        @(posedge clk);
        #1;
        check($sformatf("done_pulse[%0d]", i), o_done, 0);
        check($sformatf("ready_back[%0d]", i), ready, 1);
    endtask

    initial begin
        int dones;
        i_dv = 1'b0;
        i_ready = 1'b1;
        apply_vec(0);

        // 1x1 box
        set_tri(0, 5, 7, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 321, 0, 0, 3);
        add_frag(0, 5, 7, 321);
        // 4x4 box, coverage x+y<=3, z = 50 + x + 2y
        set_tri(1, 0, 0, 3, 3, 0, 0, 3, 1, 0, 0, 1, -1, -1, 50, 1, 2, 18);
        add_frag(1, 0, 0, 50); add_frag(1, 1, 0, 51); add_frag(1, 2, 0, 52); add_frag(1, 3, 0, 53);
        add_frag(1, 0, 1, 52); add_frag(1, 1, 1, 53); add_frag(1, 2, 1, 54);
        add_frag(1, 0, 2, 54); add_frag(1, 1, 2, 55); add_frag(1, 0, 3, 56);
        // 2x2 fully covered, z steps
        set_tri(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 100, 2, 10, 6);
        add_frag(2, 0, 0, 100); add_frag(2, 1, 0, 102); add_frag(2, 0, 1, 110); add_frag(2, 1, 1, 112);
        // z clamps low then high
        set_tri(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, -10, 0, 4);
        add_frag(3, 0, 0, 5); add_frag(3, 1, 0, 0);
        set_tri(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4090, 10, 0, 4);
        add_frag(4, 0, 0, 4090); add_frag(4, 1, 0, 4095);
        // nothing covered over 8x8, then inverted box
        set_tri(5, 0, 0, 7, 7, 0, 0, -1, 0, 0, 0, 0, 0, 0, 9, 0, 0, 66);
        set_tri(6, 4, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1);
        // negative coordinates, second pixel fails edge 2
        set_tri(7, -2, -1, -1, -1, 0, 0, 0, 1, 0, 0, 0, -1, 0, 7, 0, 0, 4);
        add_frag(7, -2, -1, 7);

        // reset
        #1 rst = 1'b1;
        #2;
        check("rst_dv", o_dv, 0);
        check("rst_done", o_done, 0);
        check("rst_xyz", {o_x, o_y, o_z}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_state", dbg_state, S_IDLE);

        for (int i = 0; i < NVEC; i++) run_case(i, 0);

        // backpressure on the 4x4 triangle
        run_case(1, 5);

        // reset in the middle of traversal
        apply_vec(1);
        i_ready = 1'b1;
        i_dv = 1'b1;
        @(posedge clk);
        #1 i_dv = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("mid_dv_before_rst", o_dv, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_dv", o_dv, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_x", o_x, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (o_done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_idle_dv", o_dv, 0);
        run_case(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
